// File: rtl/fpu_norm_round_pipe.sv
// fpu_norm_round_pipe
// Post-add normalize + round-to-nearest-even stage for the binary32 FPU.
// It takes the raw 28-bit significand sum, the larger operand's exponent and
// the resolved sign. Stage 1 normalizes (LZC, then a right or left shift) and
// stage 2 rounds and packs the result with exception flags.
// Ports:
//   clk, rst (async, active-high), flush (sync, clears both stages)
//   in_valid/in_ready, in_sign, in_exp[7:0], in_sig[27:0]
//     in_sig = {carry, hidden, frac[22:0], guard, round, sticky}
//   in_special/in_special_val : bypass value carried through unmodified
//   out_valid/out_ready, out_result[31:0], out_flags = {ovf, unf, inexact, zero}
module fpu_norm_round_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [27:0] in_sig,
  input  logic        in_special,
  input  logic [31:0] in_special_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);

  // Leading zeros of a nonzero 27-bit value. The highest set bit is scanned
  // last, so it decides the count.
  function automatic logic [4:0] lzc27(input logic [26:0] x);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i <= 26; i++) begin
      if (x[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  // RNE rounding and packing. sig = {hidden, frac[22:0], g, r, s}.
  // exp == 0 marks a subnormal. Returns {result[31:0], flags[3:0]}.
  function automatic logic [35:0] round_pack(input logic        sign,
                                             input logic [8:0]  exp,
                                             input logic [26:0] sig);
    logic        rup, inexact, ovf, unf, zero;
    logic [24:0] sum;
    logic [8:0]  e;
    logic [22:0] frac;
    logic [31:0] res;
    rup     = sig[2] & (sig[1] | sig[0] | sig[3]);
    inexact = |sig[2:0];
    sum     = {1'b0, sig[26:3]} + {24'd0, rup};
    e       = exp;
    frac    = sum[22:0];
    if (sum[24]) begin
      // 1.111..1 rounded up becomes 10.000..0
      frac = 23'd0;
      e    = exp + 9'd1;
    end else if (exp == 9'd0 && sum[23]) begin
      // The subnormal rounded up into the smallest normal
      e = 9'd1;
    end
    ovf = 1'b0;
    if (e >= 9'd255) begin
      res     = {sign, 8'hFF, 23'd0};
      ovf     = 1'b1;
      inexact = 1'b1;
    end else begin
      res = {sign, e[7:0], frac};
    end
    unf  = (res[30:23] == 8'd0) & inexact;
    zero = (res[30:0] == 31'd0);
    return {res, ovf, unf, inexact, zero};
  endfunction

  logic        vld_p1, vld_p2;
  logic        adv_p2, adv_p1, accept, load_p2;

  logic        sign_p1, special_p1;
  logic [31:0] sval_p1;
  logic [8:0]  exp_p1;
  logic [26:0] sig_p1;

  logic [31:0] res_p2;
  logic [3:0]  flags_p2;

  logic [4:0]  lz;
  logic [8:0]  lim, shamt, exp_n;
  logic [26:0] shl, sig_n;
  logic [35:0] rnd;

  // Handshake: a full pipe still accepts a beat when the output drains
  assign adv_p2   = ~vld_p2 | out_ready;
  assign adv_p1   = ~vld_p1 | adv_p2;
  assign in_ready = adv_p1 & ~flush;
  assign accept   = in_valid & in_ready;
  assign load_p2  = adv_p2 & vld_p1 & ~flush;

  always_comb begin
    lz    = lzc27(in_sig[26:0]);
    lim   = {1'b0, in_exp} - 9'd1;
    // Clamp the left shift so the exponent never drops below 1. If the hidden
    // bit is still clear after that, the value is subnormal.
    shamt = ({4'd0, lz} < lim) ? {4'd0, lz} : lim;
    shl   = in_sig[26:0] << shamt;
    sig_n = shl;
    exp_n = shl[26] ? ({1'b0, in_exp} - shamt) : 9'd0;
    if (in_sig[27]) begin
      sig_n = {in_sig[27:4], in_sig[3], in_sig[2], in_sig[1] | in_sig[0]};
      exp_n = {1'b0, in_exp} + 9'd1;
    end else if (in_sig[26:0] == 27'd0) begin
      // An all-zero significand with exponent 0 packs to a signed zero in stage 2
      sig_n = 27'd0;
      exp_n = 9'd0;
    end
  end

  // ---- stage 1 boundary: normalized significand/exponent ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv_p1) vld_p1 <= in_valid;
      if (adv_p2) vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sign_p1    <= in_sign;
      special_p1 <= in_special;
      sval_p1    <= in_special_val;
      exp_p1     <= exp_n;
      sig_p1     <= sig_n;
    end
  end

  assign rnd = round_pack(sign_p1, exp_p1, sig_p1);

  // ---- stage 2 boundary: rounded, packed result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_p2   <= 32'h0;
      flags_p2 <= 4'h0;
    end else if (load_p2) begin
      res_p2   <= special_p1 ? sval_p1 : rnd[35:4];
      flags_p2 <= special_p1 ? 4'h0 : rnd[3:0];
    end
  end

  assign out_valid  = vld_p2;
  assign out_result = res_p2;
  assign out_flags  = flags_p2;

endmodule

// File: tb/tb_fpu_norm_round_pipe.sv
module tb_fpu_norm_round_pipe;

  localparam int N = 14;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_sign, in_special;
  logic [7:0]  in_exp;
  logic [27:0] in_sig;
  logic [31:0] in_special_val;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int nvec = 0;
  int nmis = 0;

  logic        v_sign [N];
  logic [7:0]  v_exp  [N];
  logic [27:0] v_sig  [N];
  logic        v_spc  [N];
  logic [31:0] v_sval [N];
  logic [31:0] v_res  [N];
  logic [3:0]  v_flg  [N];

  int sched[$];

  fpu_norm_round_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_sig(in_sig),
    .in_special(in_special), .in_special_val(in_special_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input int i, input logic s, input logic [7:0] e, input logic [27:0] g,
                      input logic sp, input logic [31:0] sv, input logic [31:0] r, input logic [3:0] f);
    v_sign[i] = s; v_exp[i] = e; v_sig[i] = g; v_spc[i] = sp; v_sval[i] = sv;
    v_res[i] = r; v_flg[i] = f;
  endtask

  task automatic drive(input int i);
    in_sign = v_sign[i]; in_exp = v_exp[i]; in_sig = v_sig[i];
    in_special = v_spc[i]; in_special_val = v_sval[i]; in_valid = 1'b1;
  endtask

  // Feeds sched[first_b..] while draining with out_ready=1 and compares every
  // delivered beat, in order, against sched[0..].
  task automatic pump(input int first_b, input string tag);
    int b, k;
    b = first_b;
    k = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && k < sched.size(); cyc++) begin
      if (b < sched.size()) drive(sched[b]);
      else in_valid = 1'b0;
      #1;
      if (b < sched.size()) chk($sformatf("%s_in_ready[%0d]", tag, b), {31'd0, in_ready}, 32'd1);
      if (out_valid && out_ready) begin
        chk($sformatf("%s_res[%0d]", tag, k), out_result, v_res[sched[k]]);
        chk($sformatf("%s_flags[%0d]", tag, k), {28'd0, out_flags}, {28'd0, v_flg[sched[k]]});
        k++;
      end
      if (in_valid && in_ready) b++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk({tag, "_count"}, k, sched.size());
  endtask

  initial begin
    //    idx sign exp   sig            spc sval          result        flags
    setv(0,  0, 127, 28'h8000000, 0, 32'h0,        32'h40000000, 4'h0); // 1.0+1.0
    setv(1,  0, 127, 28'h0000008, 0, 32'h0,        32'h34000000, 4'h0); // cancellation lz=23
    setv(2,  0, 127, 28'h7FFFFFC, 0, 32'h0,        32'h40000000, 4'h2); // tie, odd -> up, carry
    setv(3,  0, 127, 28'h4000004, 0, 32'h0,        32'h3F800000, 4'h2); // tie, even -> stay
    setv(4,  0, 254, 28'h8000000, 0, 32'h0,        32'h7F800000, 4'hA); // overflow on normalize
    setv(5,  0, 1,   28'h2000000, 0, 32'h0,        32'h00400000, 4'h0); // clamped shift, subnormal
    setv(6,  1, 127, 28'h0000000, 0, 32'h0,        32'h80000000, 4'h1); // negative zero
    setv(7,  0, 1,   28'h3FFFFFE, 0, 32'h0,        32'h00800000, 4'h2); // subnormal rounds to normal
    setv(8,  0, 1,   28'h0000009, 0, 32'h0,        32'h00000001, 4'h6); // inexact subnormal
    setv(9,  0, 254, 28'h7FFFFFE, 0, 32'h0,        32'h7F800000, 4'hA); // overflow on round
    setv(10, 1, 127, 28'h4000000, 0, 32'h0,        32'hBF800000, 4'h0); // -1.0
    setv(11, 0, 254, 28'h8000000, 1, 32'h7FC00000, 32'h7FC00000, 4'h0); // special bypass
    setv(12, 0, 127, 28'h400000D, 0, 32'h0,        32'h3F800002, 4'h2); // above half, round up
    setv(13, 0, 127, 28'h4000003, 0, 32'h0,        32'h3F800000, 4'h2); // below half, truncate

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_exp = 8'd0; in_sig = 28'd0; in_special = 1'b0; in_special_val = 32'd0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_flags", {28'd0, out_flags}, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Latency: accept edge, then the result appears after the next edge
    step();
    drive(0);
    #1;
    chk("lat_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("lat_valid_e1", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_valid_e2", {31'd0, out_valid}, 32'd1);
    chk("lat_res", out_result, 32'h40000000);
    chk("lat_flags", {28'd0, out_flags}, 32'd0);
    step();
    chk("lat_valid_e3", {31'd0, out_valid}, 32'd0);

    // Back-to-back stream of every directed vector
    sched.delete();
    for (int i = 0; i < N; i++) sched.push_back(i);
    pump(0, "stream");

    // Backpressure: two accepts fill the pipe, then in_ready drops
    sched.delete();
    sched.push_back(0); sched.push_back(10); sched.push_back(1); sched.push_back(11);
    out_ready = 1'b0;
    drive(0);
    #1;
    chk("bp_ready0", {31'd0, in_ready}, 32'd1);
    step();
    drive(10);
    #1;
    chk("bp_ready1", {31'd0, in_ready}, 32'd1);
    step();
    drive(1);
    #1;
    chk("bp_ready_drop", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_res0", out_result, 32'h40000000);
    step();
    chk("bp_hold_res1", out_result, 32'h40000000);
    chk("bp_still_blocked", {31'd0, in_ready}, 32'd0);
    step();
    chk("bp_hold_res2", out_result, 32'h40000000);
    pump(2, "bp");

    // Flush with both stages full
    out_ready = 1'b0;
    drive(2);
    step();
    drive(3);
    step();
    chk("fl_full_valid", {31'd0, out_valid}, 32'd1);
    drive(4);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("fl_no_stale[%0d]", c), {31'd0, out_valid}, 32'd0);
    end
    sched.delete();
    sched.push_back(12);
    pump(0, "post_flush");

    // Reset mid-operation discards the in-flight beat
    drive(10);
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_res", out_result, 32'h0);
    #2;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("mrst_no_beat[%0d]", c), {31'd0, out_valid}, 32'd0);
    end
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
